// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - valid/ready write channel into the uart_tx_fifo queue
//
// Signals:
//   s_valid  master->slave  write request
//   s_data   master->slave  word to transmit (DATA_BITS wide)
//   s_ready  slave->master  queue can accept a word this cycle
interface uart_tx_fifo_if #(
    parameter int DATA_BITS = 8
);
    logic                 s_valid;
    logic [DATA_BITS-1:0] s_data;
    logic                 s_ready;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - buffered UART transmitter with a small word FIFO and run-time baud/parity
//
// Optional feature macro: JSILICON_UART_PARITY_EN (defined = parity bit support,
// undefined = no PARITY state, parity_mode ignored).
//
// Ports:
//   clock        system clock, rising edge
//   reset_n      asynchronous active-low reset
//   clk_div      bit period minus one in clocks (0 treated as 1), latched per frame
//   parity_mode  00/11 none, 01 even, 10 odd, latched per frame
//   s_if         valid/ready write channel (slave side)
//   tx           serial line, idles high (registered)
//   busy         frame in progress (registered)
//   fifo_level   words currently queued (registered)
module uart_tx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [DIV_WIDTH-1:0]          clk_div,
    input  logic [1:0]                    parity_mode,
    uart_tx_fifo_if.slave                 s_if,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic [LW-1:0] FULL_LVL  = LW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3
`ifdef JSILICON_UART_PARITY_EN
        , S_PARITY = 3'd4
`endif
    } state_t;

    // FIFO storage and bookkeeping
    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [LW-1:0]        r_level;

    // Serialiser
    state_t               r_state;
    state_t               w_state_next;
    logic [DIV_WIDTH-1:0] r_div;
    logic [DIV_WIDTH-1:0] r_cnt;
    logic [DIV_WIDTH-1:0] w_div_clamped;
    logic [3:0]           r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_next;
    logic                 r_tx;
    logic                 r_busy;
    logic                 w_tx_next;
    logic                 w_busy_next;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_empty;
    logic                 w_tick;

`ifdef JSILICON_UART_PARITY_EN
    logic                 r_par_en;
    logic                 r_par_bit;
`else
    logic                 w_unused_parity;
    assign w_unused_parity = ^parity_mode;
`endif

    // s_ready looks only at the registered level, never at s_valid
    assign s_if.s_ready  = (r_level < FULL_LVL);
    assign w_push        = s_if.s_valid && s_if.s_ready;
    assign w_empty       = (r_level == '0);
    assign w_tick        = (r_cnt == r_div);
    assign w_div_clamped = (clk_div == '0) ? DIV_WIDTH'(1) : clk_div;

    assign tx         = r_tx;
    assign busy       = r_busy;
    assign fifo_level = r_level;

    // ---------------------------------------------------------------- FIFO
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= s_if.s_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // ------------------------------------------------------ state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------------------------------------------- next-state logic
    // A pop happens only when a new frame is started, either from IDLE or
    // straight out of the last stop bit so consecutive frames have no gap.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_state_next = S_START;
                    w_pop        = 1'b1;
                end
            end
            S_START: begin
                if (w_tick) begin
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_tick && (r_bit_cnt == LAST_DATA)) begin
`ifdef JSILICON_UART_PARITY_EN
                    w_state_next = r_par_en ? S_PARITY : S_STOP;
`else
                    w_state_next = S_STOP;
`endif
                end
            end
`ifdef JSILICON_UART_PARITY_EN
            S_PARITY: begin
                if (w_tick) begin
                    w_state_next = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (w_tick && (r_bit_cnt == LAST_STOP)) begin
                    if (!w_empty) begin
                        w_state_next = S_START;
                        w_pop        = 1'b1;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // -------------------------------------------------------- output logic
    // tx/busy are registered, so they are derived from the next state and
    // the next shift-register contents.
    always_comb begin
        w_shift_next = r_shift;
        if (w_pop) begin
            w_shift_next = r_mem[r_rd_ptr];
        end else if ((r_state == S_DATA) && w_tick) begin
            w_shift_next = r_shift >> 1;
        end

        w_tx_next = 1'b1;
        case (w_state_next)
            S_START:  w_tx_next = 1'b0;
            S_DATA:   w_tx_next = w_shift_next[0];
`ifdef JSILICON_UART_PARITY_EN
            S_PARITY: w_tx_next = r_par_bit;
`endif
            default:  w_tx_next = 1'b1;
        endcase

        w_busy_next = (w_state_next != S_IDLE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_tx   <= 1'b1;
            r_busy <= 1'b0;
        end else begin
            r_tx   <= w_tx_next;
            r_busy <= w_busy_next;
        end
    end

    // ------------------------------------------------------------ datapath
    // The divisor and parity choice are captured at pop time so a frame in
    // flight is immune to register writes. The bit timer restarts at every
    // boundary, so it never exceeds the latched divisor.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt     <= '0;
            r_div     <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
`ifdef JSILICON_UART_PARITY_EN
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
`endif
        end else begin
            r_shift <= w_shift_next;
            if (w_pop) begin
                r_cnt     <= '0;
                r_bit_cnt <= '0;
                r_div     <= w_div_clamped;
`ifdef JSILICON_UART_PARITY_EN
                r_par_en  <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
                // odd parity is the inverted XOR; parity_mode[1] selects it
                r_par_bit <= (^r_mem[r_rd_ptr]) ^ parity_mode[1];
`endif
            end else if (r_state != S_IDLE) begin
                if (w_tick) begin
                    r_cnt     <= '0;
                    r_bit_cnt <= (w_state_next != r_state) ? 4'd0 : (r_bit_cnt + 4'd1);
                end else begin
                    r_cnt <= r_cnt + DIV_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised, buffered UART transmitter. It is the next generation of the single-byte `uart_tx`. Words enter through a valid/ready handshake into a small FIFO and are serialised LSB-first. Data width, stop-bit count and FIFO depth are configurable. The baud divisor and the parity mode are programmable at run time. The block sits between the core's output register path and the `tx` pad, so the core can queue several bytes without polling `busy`.

## Interface
Parameters:
- `DATA_BITS`, 8: data bits per frame; legal range 5..9.
- `STOP_BITS`, 1: stop bits per frame; 1 or 2.
- `FIFO_DEPTH`, 4: FIFO entries; power of two, at least 2.
- `DIV_WIDTH`, 16: width of `clk_div`.

Ports:
- `clock`  in  1  system clock; all logic is on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `clk_div`  in  DIV_WIDTH  bit period minus one, in clocks; values below 1 are treated as 1.
- `parity_mode`  in  2  00 = none, 01 = even, 10 = odd, 11 = none.
- `s_valid`  in  1  write request.
- `s_data`  in  DATA_BITS  word to transmit.
- `s_ready`  out  1  FIFO can accept a word (level < FIFO_DEPTH).
- `tx`  out  1  serial line; idles high.
- `busy`  out  1  a frame is in progress (state != IDLE).
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  number of words queued.

Clocking and reset are fixed: one clock; reset is asynchronous and active-low.

## Operation
- **Push:** a word is written on any rising edge where `s_valid && s_ready`. `s_data` is ignored otherwise.
- **Full FIFO:** `s_ready` is 0, so no push occurs. No overflow condition exists.
- **State machine:** IDLE, START, DATA, PARITY, STOP.
  - IDLE → START when the FIFO is non-empty. On that edge the head word is popped into the shift register, `clk_div` (clamped) is latched, and `parity_mode` is latched.
  - START → DATA after one bit period.
  - DATA → PARITY after DATA_BITS bit periods when parity is enabled; otherwise DATA → STOP.
  - PARITY → STOP after one bit period.
  - STOP → START after STOP_BITS bit periods if the FIFO is non-empty, popping the next word with no idle gap. Otherwise STOP → IDLE.
- **Line levels:** `tx` is 0 for the start bit, then data LSB first, then the parity bit, then 1 for the stop bits.
  - Even parity: XOR of the data bits.
  - Odd parity: the inverse of that XOR.
- **Latched settings:** changing `clk_div` or `parity_mode` mid-frame has no effect until the next frame.
- **Bit counter:** counts 0..latched div. The bit boundary is at count == div. The counter is DIV_WIDTH wide and must never wrap within a bit.
- **Simultaneous push and pop:** `fifo_level` is unchanged. A push into an empty FIFO on the same edge as an IDLE check is not visible until the next edge.

## Timing
- **Reset values (immediate, asynchronous):**
  - `tx` = 1, `busy` = 0, `fifo_level` = 0, `s_ready` = 1.
  - State = IDLE, FIFO pointers cleared, counters cleared.
- **Reset mid-frame:** the frame is aborted, `tx` returns to 1 immediately, and all queued words are discarded.
- **Push-to-line latency:** push accepted at edge N into an empty FIFO with the block IDLE → pop at edge N+1, and `tx` = 0 and `busy` = 1 from edge N+1.
- **Frame length:** (1 + DATA_BITS + P + STOP_BITS) × (div + 1) cycles, where P = 1 if parity is active, else 0.
- **Frame end:** `busy` falls at the edge ending the last stop bit, unless the next frame starts on that same edge.
- **Registered outputs:** `tx`, `busy` and `fifo_level` are registered. `s_ready` is combinational from `fifo_level` only and must not depend on `s_valid`.

## Configuration
- Macro: `JSILICON_UART_PARITY_EN`.
- **Defined:** the PARITY state and the `parity_mode` decoding are built as described above.
- **Undefined:** the PARITY state and the parity logic are removed. `parity_mode` is ignored, and every frame is (1 + DATA_BITS + STOP_BITS) × (div + 1) cycles.
- The port list is identical in both builds.

## Test plan
- **Single frame, 8N1:** reset, `clk_div` = 3, `parity_mode` = 00, push 0xA5 → `tx` low for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high for 4 cycles. `busy` is high for exactly 40 cycles.
- **Even parity (macro defined):** push 0x07, `parity_mode` = 01 → parity bit = 1, frame = 44 cycles.
- **Odd parity (macro defined):** push 0x03, `parity_mode` = 10 → parity bit = 1.
- **Back-to-back:** push 4 words, FIFO_DEPTH = 4 → `s_ready` = 0 when `fifo_level` = 4. The 5th `s_valid` is held off until a pop. Frames are contiguous with no extra high cycles between stop and start.
- **Mid-frame setting change:** change `clk_div` from 3 to 7 and toggle `parity_mode` during DATA → the current frame keeps 4-cycle bits and its parity setting. The next frame uses 8-cycle bits.
- **Reset mid-frame:** assert `reset_n` = 0 during DATA bit 3 with 2 words queued → `tx` = 1, `busy` = 0, `fifo_level` = 0 immediately. After release, no frame is sent.
